// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath width, memory-port arbiter state
// encoding, requester IDs and the bus command payload.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [1:0] ARB_IDLE      = 2'd0;
  localparam logic [1:0] ARB_GRANT_IF  = 2'd1;
  localparam logic [1:0] ARB_GRANT_MEM = 2'd2;
  localparam logic [1:0] ARB_RESP      = 2'd3;

  localparam logic SRC_IF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_cmd_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Cycle counter that flags the LIMIT-th enabled cycle since the last clear.
// LIMIT = 0 never expires; LIMIT must fit in CNT_W bits.
module arb_timeout_counter #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at LAST so a missed clear cannot wrap into a second expiry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = (LIMIT != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch (IF) and load/store (MEM),
// one bus transaction at a time, with fetch-starvation guard and bus timeout.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_BURST_MAX = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err,
  output logic              bus_err_src
);

  localparam int unsigned        BURST_W     = 4;
  localparam int unsigned        TMO_W       = 8;
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MEM_BURST_MAX);
  localparam logic [BURST_W-1:0] BURST_SAT   = '1;

  logic [1:0]         state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               drop_q, drop_d;
  logic               src_q, src_d;
  bus_cmd_t           cmd_q, cmd_d;
  logic               bus_req_d;
  logic               if_valid_d, mem_valid_d;
  logic [XLEN-1:0]    if_rdata_d, mem_rdata_d;
  logic               bus_err_d, bus_err_src_d;
  logic               if_live, mem_wins;
  logic               tmo_clear, tmo_enable, tmo_expire;

  assign tmo_clear  = (state_q == ARB_IDLE);
  assign tmo_enable = (state_q == ARB_GRANT_IF) || (state_q == ARB_GRANT_MEM);

  arb_timeout_counter #(
    .LIMIT (TIMEOUT),
    .CNT_W (TMO_W)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .expire_c (tmo_expire)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    burst_d       = if_req ? burst_q : '0;
    drop_d        = drop_q;
    src_d         = src_q;
    cmd_d         = cmd_q;
    bus_req_d     = bus_req;
    if_valid_d    = 1'b0;
    mem_valid_d   = 1'b0;
    if_rdata_d    = if_rdata;
    mem_rdata_d   = mem_rdata;
    bus_err_d     = 1'b0;
    bus_err_src_d = bus_err_src;

    // A fetch flushed in the arbitration cycle is not a candidate at all.
    if_live  = if_req & ~if_flush;
    mem_wins = mem_req & ~(if_live & (burst_q >= BURST_LIMIT));

    unique case (state_q)
      ARB_IDLE: begin
        if (mem_wins) begin
          state_d     = ARB_GRANT_MEM;
          src_d       = SRC_MEM;
          bus_req_d   = 1'b1;
          cmd_d.we    = mem_we;
          cmd_d.addr  = mem_addr;
          cmd_d.wdata = mem_wdata;
          cmd_d.wstrb = mem_wstrb;
          if (if_req && (burst_q != BURST_SAT)) begin
            burst_d = burst_q + BURST_W'(1);
          end
        end else if (if_live) begin
          state_d     = ARB_GRANT_IF;
          src_d       = SRC_IF;
          bus_req_d   = 1'b1;
          cmd_d.we    = 1'b0;
          cmd_d.addr  = if_addr;
          cmd_d.wdata = '0;
          cmd_d.wstrb = '0;
          burst_d     = '0;
        end
      end

      ARB_GRANT_IF, ARB_GRANT_MEM: begin
        if ((state_q == ARB_GRANT_IF) && if_flush) begin
          drop_d = 1'b1;
        end
        // An ack in the expiry cycle still completes normally.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (src_q == SRC_IF) begin
            if_rdata_d = bus_rdata;
            if_valid_d = ~(drop_q | if_flush);
          end else begin
            mem_rdata_d = bus_rdata;
            mem_valid_d = 1'b1;
          end
        end else if (tmo_expire) begin
          bus_req_d     = 1'b0;
          state_d       = ARB_IDLE;
          bus_err_d     = 1'b1;
          bus_err_src_d = src_q;
          drop_d        = 1'b0;
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
        drop_d  = 1'b0;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      burst_q     <= '0;
      drop_q      <= 1'b0;
      src_q       <= SRC_IF;
      cmd_q       <= '0;
      bus_req     <= 1'b0;
      if_valid    <= 1'b0;
      mem_valid   <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      bus_err     <= 1'b0;
      bus_err_src <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      drop_q      <= drop_d;
      src_q       <= src_d;
      cmd_q       <= cmd_d;
      bus_req     <= bus_req_d;
      if_valid    <= if_valid_d;
      mem_valid   <= mem_valid_d;
      if_rdata    <= if_rdata_d;
      mem_rdata   <= mem_rdata_d;
      bus_err     <= bus_err_d;
      bus_err_src <= bus_err_src_d;
    end
  end

  assign bus_we    = cmd_q.we;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;
  assign bus_wstrb = cmd_q.wstrb;

  assign stall_if  = if_req & ~if_valid & ~if_flush;
  assign stall_mem = mem_req & ~mem_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline.
- Sequences one bus transaction at a time through a req/ack handshake and returns data to the requester.
- Drives stall_if/stall_mem into the pipeline and hazard logic.
- Detects bus timeouts and reports them as access faults to the exception logic.

Parameters:
XLEN, 32, data/address width
MEM_BURST_MAX, 4, consecutive MEM grants allowed while IF is waiting before IF is forced a grant (1..15)
TIMEOUT, 255, cycles to wait for bus_ack before aborting; 0 disables the timeout (8-bit counter)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, level, held until if_valid or if_flush
if_addr  in  XLEN  fetch address, stable while if_req
if_flush  in  1  branch/exception redirect; discard the current fetch
if_valid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  XLEN  fetched instruction word
mem_req  in  1  data request, level, held until mem_valid
mem_we  in  1  1 = store
mem_addr  in  XLEN  data address
mem_wdata  in  XLEN  store data
mem_wstrb  in  XLEN/8  byte enables
mem_valid  out  1  one-cycle pulse, access complete
mem_rdata  out  XLEN  load data
bus_req  out  1  bus request, registered
bus_we  out  1  bus write
bus_addr  out  XLEN  bus address
bus_wdata  out  XLEN  bus write data
bus_wstrb  out  XLEN/8  bus byte enables
bus_ack  in  1  single-cycle completion; bus_rdata valid in the same cycle
bus_rdata  in  XLEN  bus read data
stall_if  out  1  IF must hold
stall_mem  out  1  MEM (and all stages upstream of it) must hold
bus_err  out  1  one-cycle pulse on timeout
bus_err_src  out  1  0 = IF, 1 = MEM; valid with bus_err

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; drop flag 0. Reset asserted mid-transaction abandons the transaction immediately and bus_req is 0 in the next cycle.
- States:
  - IDLE: no transaction outstanding.
  - GRANT_IF: fetch outstanding on the bus.
  - GRANT_MEM: data access outstanding on the bus.
  - RESP: one cycle in which if_valid or mem_valid is pulsed.
- IDLE arbitration:
  - MEM wins by default (it is the older instruction).
  - IF wins if only if_req is high, or if both are high and burst_cnt >= MEM_BURST_MAX.
  - burst_cnt increments on a MEM grant while if_req is high; it clears on any IF grant or when if_req is low.
- Grant: bus_* outputs are registered from the winner's inputs on entering GRANT_*. They stay stable and bus_req stays 1 until bus_ack.
- Completion: on bus_ack, latch bus_rdata, drop bus_req, go to RESP. In RESP, pulse the winner's valid with the latched data, then return to IDLE.
- Minimum latency: request seen in cycle N, bus_req in N+1, ack in N+1, valid in N+2. A new grant can therefore issue every 3 cycles at best.
- Stores: mem_valid is pulsed; mem_rdata is don't-care.
- Flush:
  - if_flush during GRANT_IF sets the drop flag. The bus transaction still completes, since it cannot be aborted.
  - In RESP, if_valid is suppressed when the drop flag is set; the flag then clears.
  - if_flush in the same cycle as an IDLE IF grant cancels that grant; MEM may take the port instead.
  - if_flush has no effect on MEM transactions.
- Timeout (TIMEOUT > 0):
  - tmo_cnt clears on grant and increments each cycle in GRANT_*.
  - When it reaches TIMEOUT with no ack, drop bus_req, pulse bus_err with bus_err_src, and go to IDLE without a valid pulse.
  - An ack arriving in the same cycle as expiry wins: normal completion, no error.
- Stalls (combinational):
  - stall_if = if_req & ~if_valid & ~if_flush.
  - stall_mem = mem_req & ~mem_valid.
- Requests that drop while not granted are ignored. A request that drops while granted is illegal, except if_req under flush.

Decomposition:
- Shared package cpu_pkg:
  - state encoding constants ARB_IDLE, ARB_GRANT_IF, ARB_GRANT_MEM, ARB_RESP;
  - XLEN;
  - source IDs SRC_IF = 0, SRC_MEM = 1.
- One natural sub-module: arb_timeout_counter (load/clear, enable, expire flag), reusable by the future CSR/MMIO bus.

Test Plan:
- Solo fetch: if_req, if_addr = 0x100, ack 2 cycles after bus_req, bus_rdata = 0x00500093 -> bus_addr = 0x100, if_valid one cycle after ack with if_rdata = 0x00500093, stall_if high until then.
- Contention: if_req and mem_req (load 0x2000) rise together -> MEM granted first, bus_addr = 0x2000, IF granted next; mem_valid precedes if_valid.
- Fairness: MEM_BURST_MAX = 4, mem_req held continuously with if_req high, immediate acks -> exactly 4 MEM grants, then 1 IF grant, burst_cnt back to 0.
- Flush: if_flush 1 cycle after an IF grant, ack 3 cycles later -> bus completes, no if_valid pulse, next grant proceeds normally.
- Timeout: TIMEOUT = 8, store granted, no ack -> bus_req low after 8 cycles, bus_err = 1 for one cycle with bus_err_src = 1, no mem_valid. Variant: ack in the expiry cycle -> mem_valid, no bus_err.
- Reset mid-transaction: reset during GRANT_MEM -> next cycle bus_req = 0, all outputs 0, state IDLE.
